// File: rtl/reset_seq_pkg.sv
// Shared state encoding and default timing constants for the ULX3S reset sequencer.
package reset_seq_pkg;

   typedef enum logic [2:0] {
      ASSERT,
      WAIT_LOCK,
      HOLD,
      RELEASE,
      RUN
   } state_t;

   localparam int DEF_LOCK_FILTER = 16;
   localparam int DEF_HOLD_CYCLES = 1024;
   localparam int DEF_STAGES      = 3;
   localparam int DEF_STAGE_GAP   = 8;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level; clears to 0 on reset.
module sync2 (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/ulx3s_reset_sequencer.sv
// Staged reset release (memory, CPU units, CPU) driven by the filtered PLL lock,
// with CPU soft reset and a saturating lock-loss counter.
module ulx3s_reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int LOCK_FILTER = DEF_LOCK_FILTER,
   parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
   parameter int STAGES      = DEF_STAGES,
   parameter int STAGE_GAP   = DEF_STAGE_GAP
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              locked,
   input  logic              soft_reset_req,
   output logic [STAGES-1:0] reset_out,
   output logic              ready,
   output logic [7:0]        lock_loss_count,
   output state_t            debugState
);

   localparam int REL_MAX = (STAGES - 1) * STAGE_GAP;
   localparam int FILT_W  = $clog2(LOCK_FILTER + 1);
   localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);
   localparam int REL_W   = (REL_MAX > 0) ? $clog2(REL_MAX + 1) : 1;

   state_t              state;
   logic                lockedS;
   logic                lockLoss;
   logic [FILT_W-1:0]   filtCnt;
   logic [FILT_W-1:0]   filtNext;
   logic [HOLD_W-1:0]   holdCnt;
   logic [REL_W-1:0]    relCnt;
   logic [REL_W-1:0]    relNext;

   sync2 lockSync (
      .clock (clock),
      .reset (reset),
      .d     (locked),
      .q     (lockedS)
   );

   assign filtNext   = filtCnt + 1'b1;
   assign relNext    = relCnt + 1'b1;
   assign debugState = state;

   // Lock only matters once the filter has passed; WAIT_LOCK handles its own drops.
   assign lockLoss = !lockedS && (state == HOLD || state == RELEASE || state == RUN);

   // soft_reset_req is a one-cycle request pulse with no acknowledge: it is
   // acted on only when sampled high in RUN and silently dropped otherwise.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state           <= ASSERT;
         filtCnt         <= '0;
         holdCnt         <= '0;
         relCnt          <= '0;
         reset_out       <= '1;
         ready           <= 1'b0;
         lock_loss_count <= '0;
      end else if (lockLoss) begin
         state     <= WAIT_LOCK;
         filtCnt   <= '0;
         holdCnt   <= '0;
         relCnt    <= '0;
         reset_out <= '1;
         ready     <= 1'b0;
         if (!reset_out[0] && lock_loss_count != 8'hFF)
            lock_loss_count <= lock_loss_count + 8'd1;
      end else begin
         case (state)
            ASSERT: state <= WAIT_LOCK;

            WAIT_LOCK: begin
               if (!lockedS) begin
                  filtCnt <= '0;
               end else if (filtNext == FILT_W'(LOCK_FILTER)) begin
                  filtCnt <= '0;
                  holdCnt <= '0;
                  state   <= HOLD;
               end else begin
                  filtCnt <= filtNext;
               end
            end

            HOLD: begin
               if (holdCnt == HOLD_W'(HOLD_CYCLES - 1)) begin
                  // Stage 0 drops on the same edge that leaves HOLD.
                  holdCnt   <= '0;
                  relCnt    <= '0;
                  reset_out <= ~STAGES'(1);
                  ready     <= (STAGES == 1);
                  state     <= (STAGES == 1) ? RUN : RELEASE;
               end else begin
                  holdCnt <= holdCnt + 1'b1;
               end
            end

            RELEASE: begin
               relCnt <= relNext;
               for (int i = 1; i < STAGES; i++) begin
                  if (relNext == REL_W'(i * STAGE_GAP))
                     reset_out[i] <= 1'b0;
               end
               if (relNext == REL_W'(REL_MAX)) begin
                  ready <= 1'b1;
                  state <= RUN;
               end
            end

            RUN: begin
               if (soft_reset_req) begin
                  holdCnt   <= '0;
                  reset_out <= '1;
                  ready     <= 1'b0;
                  state     <= HOLD;
               end
            end

            default: state <= ASSERT;
         endcase
      end
   end

endmodule

// File: tb/tb_ulx3s_reset_sequencer.sv
// Directed plus randomized bench for ulx3s_reset_sequencer against a timeline-based
// reference model (release times computed from an anchor cycle).
module tb_ulx3s_reset_sequencer;
   import reset_seq_pkg::*;

   localparam int LF   = 4;
   localparam int HOLD = 8;
   localparam int S    = 3;
   localparam int GAP  = 2;

   logic          clock;
   logic          reset;
   logic          locked;
   logic          softResetReq;
   logic [S-1:0]  resetOut;
   logic          ready;
   logic [7:0]    lockLossCount;
   state_t        debugState;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   // Reference model: while armed, stage i is released from cycle mAnchor + i*GAP.
   bit mArmed;
   int mStreak;
   int mAnchor;
   int mLoss;
   bit dly1;
   bit dly2;

   ulx3s_reset_sequencer #(
      .LOCK_FILTER (LF),
      .HOLD_CYCLES (HOLD),
      .STAGES      (S),
      .STAGE_GAP   (GAP)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .locked          (locked),
      .soft_reset_req  (softResetReq),
      .reset_out       (resetOut),
      .ready           (ready),
      .lock_loss_count (lockLossCount),
      .debugState      (debugState)
   );

   initial clock = 1'b0;
   always #20 clock = ~clock;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic logic [S-1:0] expResetOut();
      logic [S-1:0] r;
      r = '1;
      if (mArmed)
         for (int i = 0; i < S; i++) r[i] = (cyc < mAnchor + i * GAP);
      return r;
   endfunction

   function automatic logic expReady();
      return mArmed && (cyc >= mAnchor + (S - 1) * GAP);
   endfunction

   task automatic checkOutputs();
      check("reset_out", 8'(resetOut), 8'(expResetOut()));
      check("ready", 8'(ready), 8'(expReady()));
      check("lock_loss_count", lockLossCount, 8'(mLoss));
   endtask

   // Advance the model by the rules for cycle cyc, with these inputs held during it.
   task automatic modelStep(input bit lockVal, input bit softVal);
      bit ls;
      ls = dly2;
      if (!mArmed) begin
         if (cyc >= 1) begin
            mStreak = ls ? mStreak + 1 : 0;
            if (mStreak == LF) begin
               mArmed  = 1'b1;
               mAnchor = cyc + 1 + HOLD;
            end
         end
      end else if (!ls) begin
         if (cyc >= mAnchor && mLoss < 255) mLoss++;
         mArmed  = 1'b0;
         mStreak = 0;
      end else if (softVal && cyc >= mAnchor + (S - 1) * GAP) begin
         mAnchor = cyc + 1 + HOLD;
      end
      dly2 = dly1;
      dly1 = lockVal;
   endtask

   task automatic stepCycle(input bit lockVal, input bit softVal);
      locked       = lockVal;
      softResetReq = softVal;
      modelStep(lockVal, softVal);
      @(posedge clock);
      #1;
      cyc++;
      softResetReq = 1'b0;
      checkOutputs();
   endtask

   task automatic runTo(input int target, input bit lockVal);
      for (int k = 0; k < 2000 && cyc < target; k++) stepCycle(lockVal, 1'b0);
   endtask

   task automatic applyReset();
      reset        = 1'b1;
      softResetReq = 1'b0;
      repeat (2) @(posedge clock);
      locked = 1'b1;
      @(negedge clock);
      reset   = 1'b0;
      cyc     = 0;
      mArmed  = 1'b0;
      mStreak = 0;
      mAnchor = 0;
      mLoss   = 0;
      dly1    = 1'b0;
      dly2    = 1'b0;
      #1;
      checkOutputs();
      check("state_after_reset", 8'(debugState), 8'(ASSERT));
   endtask

   initial begin
      int m;
      bit lv;
      reset        = 1'b1;
      locked       = 1'b1;
      softResetReq = 1'b0;
      applyReset();

      // Clean startup
      runTo(13, 1'b1);
      check("start_c13_rst", 8'(resetOut), 8'h07);
      runTo(14, 1'b1);
      check("start_c14_rst", 8'(resetOut), 8'h06);
      runTo(16, 1'b1);
      check("start_c16_rst", 8'(resetOut), 8'h04);
      runTo(17, 1'b1);
      check("start_c17_ready", 8'(ready), 8'h00);
      runTo(18, 1'b1);
      check("start_c18_rst", 8'(resetOut), 8'h00);
      check("start_c18_ready", 8'(ready), 8'h01);
      check("start_count", lockLossCount, 8'h00);
      runTo(24, 1'b1);

      // Lock loss in RUN, then relock
      m = cyc;
      stepCycle(1'b0, 1'b0);
      stepCycle(1'b0, 1'b0);
      check("loss_m2_rst", 8'(resetOut), 8'h00);
      stepCycle(1'b0, 1'b0);
      check("loss_m3_rst", 8'(resetOut), 8'h07);
      check("loss_m3_ready", 8'(ready), 8'h00);
      check("loss_m3_count", lockLossCount, 8'h01);
      runTo(m + 6, 1'b0);
      m = cyc;
      runTo(m + 13, 1'b1);
      check("relock_13_rst", 8'(resetOut), 8'h07);
      runTo(m + 14, 1'b1);
      check("relock_14_rst", 8'(resetOut), 8'h06);
      runTo(m + 18, 1'b1);
      check("relock_18_ready", 8'(ready), 8'h01);
      runTo(m + 22, 1'b1);

      // Soft reset in RUN
      m = cyc;
      stepCycle(1'b1, 1'b1);
      check("soft_1_rst", 8'(resetOut), 8'h07);
      runTo(m + 8, 1'b1);
      check("soft_8_rst", 8'(resetOut), 8'h07);
      runTo(m + 9, 1'b1);
      check("soft_9_rst", 8'(resetOut), 8'h06);
      runTo(m + 11, 1'b1);
      check("soft_11_rst", 8'(resetOut), 8'h04);
      runTo(m + 13, 1'b1);
      check("soft_13_ready", 8'(ready), 8'h01);
      check("soft_count", lockLossCount, 8'h01);
      runTo(m + 16, 1'b1);

      // Soft reset pulses during HOLD and RELEASE are ignored
      m = cyc;
      stepCycle(1'b1, 1'b1);
      runTo(m + 3, 1'b1);
      stepCycle(1'b1, 1'b1);
      runTo(m + 10, 1'b1);
      stepCycle(1'b1, 1'b1);
      check("ignore_11_rst", 8'(resetOut), 8'h04);
      runTo(m + 13, 1'b1);
      check("ignore_13_rst", 8'(resetOut), 8'h00);
      check("ignore_13_ready", 8'(ready), 8'h01);
      runTo(m + 16, 1'b1);

      // Lock glitch while filtering: high 3, low 1, high
      runTo(cyc + 6, 1'b0);
      m = cyc;
      stepCycle(1'b1, 1'b0);
      stepCycle(1'b1, 1'b0);
      stepCycle(1'b1, 1'b0);
      stepCycle(1'b0, 1'b0);
      runTo(m + 17, 1'b1);
      check("glitch_17_rst", 8'(resetOut), 8'h07);
      runTo(m + 18, 1'b1);
      check("glitch_18_rst", 8'(resetOut), 8'h06);
      runTo(m + 22, 1'b1);
      check("glitch_22_ready", 8'(ready), 8'h01);
      check("glitch_count", lockLossCount, 8'h02);

      // Third loss, then async reset in the middle of RELEASE
      runTo(cyc + 4, 1'b0);
      check("third_loss_count", lockLossCount, 8'h03);
      m = cyc;
      runTo(m + 15, 1'b1);
      check("midrel_rst", 8'(resetOut), 8'h06);
      #2 reset = 1'b1;
      #1;
      check("async_rst", 8'(resetOut), 8'h07);
      check("async_ready", 8'(ready), 8'h00);
      check("async_count", lockLossCount, 8'h00);
      applyReset();
      runTo(30, 1'b1);

      // Randomized lock drops and soft reset pulses
      lv = 1'b1;
      for (int k = 0; k < 1500; k++) begin
         if (lv) begin
            if ($urandom_range(0, 99) < 2) lv = 1'b0;
         end else if ($urandom_range(0, 99) < 25) begin
            lv = 1'b1;
         end
         stepCycle(lv, $urandom_range(0, 99) < 6);
      end

      // Drive enough post-release losses to saturate the counter
      for (int k = 0; k < 260; k++) begin
         for (int j = 0; j < 22; j++) stepCycle(1'b1, 1'b0);
         for (int j = 0; j < 3; j++) stepCycle(1'b0, 1'b0);
      end
      check("sat_count", lockLossCount, 8'hFF);
      runTo(cyc + 25, 1'b1);
      check("sat_ready", 8'(ready), 8'h01);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ulx3s_reset_sequencer.md
# ulx3s_reset_sequencer

Reset sequencer that consumes the ULX3S PLL `locked` flag and produces staged, glitch-free, active-high reset outputs for the derived clock domains: memory first, then CPU units, then CPU. It runs in a single clock domain: the 25 MHz board clock feeding the PLL. It also supports a CPU-requested soft reset, and counts PLL lock-loss events for debug readout.

## Interface
Parameters:
- `LOCK_FILTER`, 16: consecutive synchronized-lock cycles required before the hold phase starts (≥1).
- `HOLD_CYCLES`, 1024: cycles all resets stay asserted after the lock filter passes (≥1).
- `STAGES`, 3: number of reset outputs (1..8). Bit 0 = memory, 1 = CPU units, 2 = CPU.
- `STAGE_GAP`, 8: cycles between successive stage releases (≥1).

Ports:
- `clock`, in, 1: 25 MHz board clock.
- `reset`, in, 1: reset, asynchronous, active-high.
- `locked`, in, 1: PLL lock, asynchronous to `clock`.
- `soft_reset_req`, in, 1: single-cycle pulse, synchronous to `clock`.
- `reset_out`, out, STAGES: per-domain resets, active-high, registered.
- `ready`, out, 1: high when all stages are released.
- `lock_loss_count`, out, 8: saturating count of lock losses after first release.

## Operation
- On `reset`: state=ASSERT. `reset_out` = all ones, `ready`=0, `lock_loss_count`=0, all counters 0. All outputs take effect asynchronously.
- `locked` passes through a 2-flop synchronizer to give `locked_s`. Only `locked_s` is used internally.
- States:
  - ASSERT: advance to WAIT_LOCK on the next cycle.
  - WAIT_LOCK: the filter counter increments while `locked_s`=1 and clears when `locked_s`=0. On reaching LOCK_FILTER, go to HOLD.
  - HOLD: count HOLD_CYCLES cycles, then go to RELEASE.
  - RELEASE: release `reset_out[i]` at i*STAGE_GAP cycles after RELEASE entry. After the final stage is released, go to RUN.
  - RUN: steady state.
- Lock loss: `locked_s`=0 in HOLD, RELEASE or RUN has these effects on the next cycle:
  - all `reset_out`=1 and `ready`=0;
  - state=WAIT_LOCK and counters cleared;
  - `lock_loss_count` increments only if at least stage 0 had been released. It saturates at 255.
- Soft reset: `soft_reset_req`=1 in RUN sets all `reset_out`=1 on the next cycle and sends state to HOLD. `soft_reset_req` is ignored in every other state.
- Simultaneous lock loss and soft reset: lock loss wins.
- Stage ordering is strictly ascending. A higher-index stage is never released before a lower-index one. Every assertion is all-stages-at-once.
- `ready` = ~`reset_out[STAGES-1]`, registered together with `reset_out`.
- Counter widths: $clog2(max+1) of the corresponding parameter (the RELEASE counter uses (STAGES-1)*STAGE_GAP). No wrap occurs, because counters stop at their terminal value.

## Timing
- Cycle n means the state after the n-th rising clock edge following `reset` deassertion. `locked` is held high from before edge 1.
- `locked_s`=1 from cycle 2.
- WAIT_LOCK filter occupies cycles 2..(1+LOCK_FILTER). HOLD is the next HOLD_CYCLES cycles.
- `reset_out[0]`=0 from cycle 2+LOCK_FILTER+HOLD_CYCLES.
- `reset_out[i]` falls i*STAGE_GAP cycles later.
- `ready` rises in the same cycle as `reset_out[STAGES-1]` falls.
- Lock-loss response: `locked` low at the input gives all resets asserted 3 cycles later (2 synchronizer cycles + 1 register cycle).
- Soft-reset response: 1 cycle.
- Asynchronous `reset` mid-operation asserts all outputs immediately and clears `lock_loss_count`.

## Structure
- Package `reset_seq_pkg` holds:
  - the state enum {ASSERT, WAIT_LOCK, HOLD, RELEASE, RUN};
  - default constants for LOCK_FILTER, HOLD_CYCLES, STAGES, STAGE_GAP.
- Sub-module `sync2`: 2-flop synchronizer with async active-high reset to 0, used for `locked`.
- The FSM, counters and output registers live in the top module. All outputs are driven directly from flops, never combinationally.

## Test plan
All scenarios use LOCK_FILTER=4, HOLD_CYCLES=8, STAGE_GAP=2, STAGES=3.
- Clean startup, `locked` high before edge 1:
  - `reset_out[0]` falls at cycle 14, `[1]` at 16, `[2]` at 18;
  - `ready` rises at 18;
  - `lock_loss_count`=0.
- Lock glitch during WAIT_LOCK (`locked_s` high 3 cycles, then low 1 cycle, then high): the filter restarts, release is delayed accordingly, and the count stays 0.
- Lock loss in RUN: all resets high 3 cycles after `locked` falls, `ready`=0, `lock_loss_count`=1. On relock, the full sequence repeats.
- Soft reset in RUN: all resets high next cycle. After 8 HOLD cycles, stages release at +0/+2/+4. Count unchanged.
- `soft_reset_req` pulsed during HOLD and during RELEASE: ignored, and release timing is unchanged.
- Async `reset` asserted mid-RELEASE with `lock_loss_count`=3: all outputs go to reset values immediately and the count reads 0.
